// File: rtl/keyword_scope_tracker.sv
// keyword_scope_tracker
//   Tracks nested `begin_keywords / `end_keywords scopes between the token
//   lexer and the parser. Directive tokens are consumed. Every other token is
//   forwarded through one output register stage, tagged with the keyword
//   version in force and whether an IDENT is reserved under that version.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     input handshake; in_ready = !out_valid || out_ready
//   in_kind               0=IDENT 1=BEGIN_KW 2=END_KW 3=OTHER 4=EOF (5..7 = OTHER)
//   in_ver                version code carried by BEGIN_KW (8..15 invalid)
//   in_kwmask             bit v set = IDENT is reserved in version v
//   in_payload            opaque token data, passed through unchanged
//   out_valid/out_ready   output handshake
//   out_kind              forwarded kind (0, 3 or 4)
//   out_is_kw             IDENT reserved under out_ver
//   out_ver               version in force when the token was accepted
//   out_payload           forwarded payload
//   depth                 current number of valid stack entries
//   err_pulse             [0]=underflow [1]=overflow [2]=bad version [3]=unbalanced at EOF
//   err_sticky            OR-accumulation of err_pulse, cleared by reset only
module keyword_scope_tracker #(
    parameter int unsigned DEPTH       = 8,
    parameter logic [2:0]  DEFAULT_VER = 3'd7,
    parameter int unsigned PAYLOAD_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_kind,
    input  logic [3:0]           in_ver,
    input  logic [7:0]           in_kwmask,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           out_kind,
    output logic                 out_is_kw,
    output logic [2:0]           out_ver,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [3:0]           depth,
    output logic [3:0]           err_pulse,
    output logic [3:0]           err_sticky
);

    typedef enum logic [2:0] {
        KIND_IDENT    = 3'd0,
        KIND_BEGIN_KW = 3'd1,
        KIND_END_KW   = 3'd2,
        KIND_OTHER    = 3'd3,
        KIND_EOF      = 3'd4
    } kind_t;

    localparam logic [3:0] DEPTH_MAX = 4'(DEPTH);

    // Sized to the full 4-bit depth range so any depth value indexes safely;
    // only the lowest DEPTH entries are ever written.
    logic [2:0] stack [16];
    // Counts BEGIN_KWs rejected while full, so their END_KWs are absorbed
    // without popping scopes that were genuinely pushed.
    logic [3:0] ovf_cnt;

    logic       accept;
    logic       fwd;
    logic       push;
    logic       pop;
    logic       ovf_inc;
    logic       ovf_dec;
    logic       eof_clear;
    logic [2:0] cur_ver;
    logic [2:0] push_ver;
    logic [2:0] fwd_kind;
    logic       fwd_is_kw;
    logic [3:0] err_n;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign cur_ver  = (depth == 4'd0) ? DEFAULT_VER : stack[depth - 4'd1];

    always_comb begin
        fwd       = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        ovf_inc   = 1'b0;
        ovf_dec   = 1'b0;
        eof_clear = 1'b0;
        err_n     = '0;
        push_ver  = in_ver[2:0];
        fwd_kind  = (in_kind > KIND_EOF) ? KIND_OTHER : in_kind;
        fwd_is_kw = (in_kind == KIND_IDENT) && in_kwmask[cur_ver];

        if (accept) begin
            case (in_kind)
                KIND_BEGIN_KW: begin
                    // A bad version still occupies a slot (holding the outer
                    // version) so its matching END_KW pops the right entry.
                    if (in_ver[3]) begin
                        err_n[2] = 1'b1;
                        push_ver = cur_ver;
                    end
                    if (depth == DEPTH_MAX) begin
                        err_n[1] = 1'b1;
                        ovf_inc  = (ovf_cnt != 4'd15);
                    end else begin
                        push = 1'b1;
                    end
                end
                KIND_END_KW: begin
                    if (ovf_cnt != 4'd0) begin
                        ovf_dec = 1'b1;
                    end else if (depth != 4'd0) begin
                        pop = 1'b1;
                    end else begin
                        err_n[0] = 1'b1;
                    end
                end
                KIND_EOF: begin
                    fwd       = 1'b1;
                    eof_clear = 1'b1;
                    err_n[3]  = (depth != 4'd0) || (ovf_cnt != 4'd0);
                end
                default: fwd = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            stack[depth] <= push_ver;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_kind    <= 3'd0;
            out_is_kw   <= 1'b0;
            out_ver     <= DEFAULT_VER;
            out_payload <= '0;
            depth       <= 4'd0;
            ovf_cnt     <= 4'd0;
            err_pulse   <= '0;
            err_sticky  <= '0;
        end else begin
            if (in_ready) begin
                out_valid <= fwd;
            end
            if (fwd) begin
                out_kind    <= fwd_kind;
                out_is_kw   <= fwd_is_kw;
                out_ver     <= cur_ver;
                out_payload <= in_payload;
            end

            if (eof_clear) begin
                depth <= 4'd0;
            end else if (push) begin
                depth <= depth + 4'd1;
            end else if (pop) begin
                depth <= depth - 4'd1;
            end

            if (eof_clear) begin
                ovf_cnt <= 4'd0;
            end else if (ovf_inc) begin
                ovf_cnt <= ovf_cnt + 4'd1;
            end else if (ovf_dec) begin
                ovf_cnt <= ovf_cnt - 4'd1;
            end

            err_pulse  <= err_n;
            err_sticky <= err_sticky | err_n;
        end
    end

endmodule
